level_pwm: RTL

//  Downstream consumer of the 2-bit up/down level FSM output y[1:0]. Converts the level into a
//  PWM waveform of duty 0%, 25%, 50% or 75% for an LED/driver stage.

---
 rtl/level_pwm.sv | 85 ++++++++
 1 files changed

// File: rtl/level_pwm.sv
// Level-to-PWM converter: turns a 2-bit duty level into a 0/25/50/75% waveform whose
// duty only changes at period boundaries, with period-start and level-change pulses.
module level_pwm #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] level,
    output logic       pwm_out,
    output logic       period_start,
    output logic       level_changed,
    output logic [1:0] active_level
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PSC_W-1:0] PSC_ZERO = {PSC_W{1'b0}};
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    logic             run_r;
    logic [PSC_W-1:0] psc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;
    logic             boundary_s;
    logic [CNT_W-1:0] duty_thresh_s;

    // Tick, boundary and duty threshold (level * quarter period, never reaches 2**CNT_W)
    always_comb begin
        tick_s        = run_r && en && (psc_r == PSC_LAST);
        boundary_s    = tick_s && (cnt_r == CNT_LAST);
        duty_thresh_s = CNT_W'(active_level) << (CNT_W - 2);
    end

    // Run/prescaler/period state, level latch and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_r         <= 1'b0;
            psc_r         <= PSC_ZERO;
            cnt_r         <= CNT_ZERO;
            active_level  <= 2'b00;
            pwm_out       <= 1'b0;
            period_start  <= 1'b0;
            level_changed <= 1'b0;
        end else if (!en) begin
            run_r         <= 1'b0;
            psc_r         <= PSC_ZERO;
            cnt_r         <= CNT_ZERO;
            pwm_out       <= 1'b0;
            period_start  <= 1'b0;
            level_changed <= 1'b0;
        end else if (!run_r) begin
            run_r         <= 1'b1;
            psc_r         <= PSC_ZERO;
            cnt_r         <= CNT_ZERO;
            active_level  <= level;
            pwm_out       <= 1'b0;
            period_start  <= 1'b1;
            level_changed <= (level != active_level);
        end else begin
            // Compare uses the pre-edge counter, giving one clock of latency from cnt
            pwm_out <= (cnt_r < duty_thresh_s);
            if (tick_s) begin
                psc_r <= PSC_ZERO;
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                psc_r <= psc_r + PSC_ONE;
            end
            if (boundary_s) begin
                active_level  <= level;
                period_start  <= 1'b1;
                level_changed <= (level != active_level);
            end else begin
                period_start  <= 1'b0;
                level_changed <= 1'b0;
            end
        end
    end

endmodule
